// File: rtl/ret_stack.sv
// Return-address stack with a zero-latency top-of-stack read for next-PC selection.
// RET_STACK_ERR_CHECK_EN: drop push-at-full/pop-at-empty with sticky ovf/unf; otherwise circular overwrite.
module ret_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wesp,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] ret_in,
  output logic [AW-1:0] ret_out,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef RET_STACK_ERR_CHECK_EN
  localparam logic BLOCK_AT_FULL = 1'b1;
`else
  localparam logic BLOCK_AT_FULL = 1'b0;
`endif

  logic [AW-1:0] mem [DEPTH];
  logic [CW-1:0] cnt;
  // ptr tracks the next free slot independently of cnt so the circular
  // mode can keep wrapping after cnt saturates at DEPTH.
  logic [PW-1:0] ptr;
  logic [PW-1:0] top;
  logic          do_push;
  logic          do_pop;
  logic          do_repl;

  assign top     = ptr - PW'(1);
  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign ret_out = empty ? '0 : mem[top];

  always_comb begin
    do_repl = wesp && push && pop && !empty;
    do_push = wesp && push && (!pop || empty) && !(BLOCK_AT_FULL && full);
    do_pop  = wesp && pop && !push && !empty;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_repl) begin
        mem[top] <= ret_in;
      end else if (do_push) begin
        mem[ptr] <= ret_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      ptr <= '0;
    end else if (do_push) begin
      ptr <= ptr + PW'(1);
      if (!full) begin
        cnt <= cnt + CW'(1);
      end
    end else if (do_pop) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - CW'(1);
    end
  end

`ifdef RET_STACK_ERR_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (wesp && push && !pop && full) begin
        ovf <= 1'b1;
      end
      if (wesp && pop && !push && empty) begin
        unf <= 1'b1;
      end
    end
  end
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_ret_stack.sv
// Scoreboard bench for ret_stack: queue-based reference model feeds expected
// outputs to a monitor that compares on every falling clock edge.
module tb_ret_stack;

  localparam int AW    = 10;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wesp = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [AW-1:0] ret_in = '0;
  logic [AW-1:0] ret_out;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          unf;

  always #5 clk = ~clk;

  ret_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .wesp   (wesp),
    .push   (push),
    .pop    (pop),
    .ret_in (ret_in),
    .ret_out(ret_out),
    .empty  (empty),
    .full   (full),
    .ovf    (ovf),
    .unf    (unf)
  );

  typedef struct packed {
    logic [AW-1:0] ret;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] model[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  int            total = 0;
  int            bad = 0;

  function automatic exp_t model_outputs();
    exp_t e;
    e.ret   = (model.size() == 0) ? '0 : model[model.size()-1];
    e.empty = (model.size() == 0);
    e.full  = (model.size() == DEPTH);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  // Applies one clock of stimulus, advances the model, queues the expectation.
  task automatic cycle(input logic r, input logic w, input logic pu,
                       input logic po, input logic [AW-1:0] d);
    reset = r; wesp = w; push = pu; pop = po; ret_in = d;
    @(posedge clk);
    if (r) begin
      model.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (w) begin
      if (pu && po) begin
        if (model.size() == 0) model.push_back(d);
        else model[model.size()-1] = d;
      end else if (pu) begin
        if (model.size() == DEPTH) begin
`ifdef RET_STACK_ERR_CHECK_EN
          m_ovf = 1'b1;
`else
          void'(model.pop_front());
          model.push_back(d);
`endif
        end else begin
          model.push_back(d);
        end
      end else if (po) begin
        if (model.size() == 0) begin
`ifdef RET_STACK_ERR_CHECK_EN
          m_unf = 1'b1;
`endif
        end else begin
          void'(model.pop_back());
        end
      end
    end
    exp_q.push_back(model_outputs());
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ret_out", ret_out, e.ret);
      chk("empty", AW'(empty), AW'(e.empty));
      chk("full", AW'(full), AW'(e.full));
      chk("ovf", AW'(ovf), AW'(e.ovf));
      chk("unf", AW'(unf), AW'(e.unf));
    end
  end

  initial begin
    int unsigned pp;
    // reset check
    cycle(1, 0, 0, 0, '0);

    // ordering
    cycle(0, 1, 1, 0, 10'h005);
    cycle(0, 1, 1, 0, 10'h012);
    cycle(0, 1, 1, 0, 10'h3FF);
    // wesp gate
    cycle(0, 0, 1, 0, 10'h111);
    cycle(0, 0, 0, 1, 10'h111);
    repeat (3) cycle(0, 1, 0, 1, '0);

    // replace, and push+pop while empty acts as a push
    cycle(0, 1, 1, 0, 10'h020);
    cycle(0, 1, 1, 1, 10'h030);
    cycle(0, 1, 0, 1, '0);
    cycle(0, 1, 1, 1, 10'h044);
    cycle(0, 1, 0, 1, '0);

    // reset in the middle of a call sequence
    cycle(0, 1, 1, 0, 10'h0AB);
    cycle(0, 1, 1, 0, 10'h0CD);
    cycle(1, 1, 1, 0, 10'h0EF);
    cycle(0, 1, 0, 1, '0);

`ifdef RET_STACK_ERR_CHECK_EN
    cycle(1, 0, 0, 0, '0);
    for (int i = 1; i <= 16; i++) cycle(0, 1, 1, 0, AW'(10'h100 + i));
    cycle(0, 1, 1, 0, 10'h2AA);
    cycle(0, 1, 1, 1, 10'h155);
    repeat (17) cycle(0, 1, 0, 1, '0);
`else
    cycle(1, 0, 0, 0, '0);
    for (int i = 1; i <= 17; i++) cycle(0, 1, 1, 0, AW'(i));
    repeat (16) cycle(0, 1, 0, 1, '0);
    cycle(0, 1, 0, 1, '0);
`endif

    // randomized phases alternating push-heavy and pop-heavy traffic
    cycle(1, 0, 0, 0, '0);
    for (int ph = 0; ph < 8; ph++) begin
      pp = (ph % 2 == 0) ? 75 : 25;
      for (int n = 0; n < 60; n++) begin
        cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < pp) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < (100 - pp)) ? 1'b1 : 1'b0,
              AW'($urandom));
      end
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
